frame_scheduler: RTL and testbench
==================================

// Module: frame_scheduler
// PURPOSE
//  Generates the game frame tick from CLOCK_50 and sequences the per-frame work.
//  On each tick it issues start pulses to NUM_TASKS engines in fixed order
//  (e.g. 0=input/physics, 1=collision, 2=render) and waits for each one's done.
//  Also keeps the frame-in-second and seconds counters that feed the HEX
//  displays, and flags frames whose work overran the next tick.
// PARAMETERS
//  TICK_DIV        1_666_666  tick period = TICK_DIV+1 clocks (30 Hz at 50 MHz)
//  FRAMES_PER_SEC  30         frame_num wraps FRAMES_PER_SEC-1 -> 0
//  NUM_TASKS       3          number of sequenced engines (1..8)
// PORTS
//  CLOCK_50       in   1          system clock, rising edge
//  resetn         in   1          asynchronous, active-low reset
//  enable         in   1          1 = tick divider runs; 0 = divider frozen (pause)
//  clear_overrun  in   1          synchronous clear of overrun_count
//  task_done      in   NUM_TASKS  per-engine done level/pulse, sampled in WAIT only
//  task_start     out  NUM_TASKS  one-hot, 1-cycle start pulse
//  frame_tick     out  1          1-cycle pulse per frame period
//  busy           out  1          1 while a frame's task sequence is in progress
//  frame_num      out  5          frame index within second, 0..FRAMES_PER_SEC-1
//  seconds        out  8          elapsed seconds, wraps 255 -> 0
//  overrun_count  out  8          ticks that arrived while busy, saturates at 255
// BEHAVIOUR
//  Reset (async, resetn=0): divider=0, all outputs 0, FSM=IDLE, task index=0.
//  Divider: increments only when enable=1. When it equals TICK_DIV with enable=1,
//   it returns to 0 and frame_tick is registered high for exactly the next cycle.
//   First tick is TICK_DIV+1 enabled cycles after reset release.
//  Counters: on each frame_tick, frame_num increments. FRAMES_PER_SEC-1 wraps to 0
//   and seconds increments in the same cycle. Advance happens even on overrun.
//  FSM states: IDLE, START, WAIT; idx register 0..NUM_TASKS-1.
//   IDLE : frame_tick=1 -> idx=0, START.
//   START: task_start[idx]=1 for this single cycle -> WAIT.
//   WAIT : task_done[idx]=1 -> idx==NUM_TASKS-1 ? IDLE : (idx+1, START).
//          task_done bits other than idx are ignored.
//  Latency: tick in cycle N -> task_start[0] in N+1. Earliest done sample is N+2.
//   Each later start is 1 cycle after the previous done is sampled.
//  busy = (state != IDLE), registered with the state.
//  Overrun: frame_tick while state != IDLE -> overrun_count+1 (hold at 255).
//   The tick is dropped and the current sequence continues undisturbed.
//  clear_overrun has priority over a same-cycle increment (result 0).
//  enable=0 pauses only the divider; an in-progress sequence still completes.
//  Reset mid-sequence: immediate return to IDLE, no further start pulses.
// TESTING (sim with TICK_DIV=9, FRAMES_PER_SEC=30, NUM_TASKS=3)
//  T1 reset release, enable=1, no tasks busy -> frame_tick at cycles 10,20,30...;
//     all outputs 0 before cycle 10.
//  T2 done returned 2 cycles after each start -> starts 0,1,2 at tick+1, +4, +7;
//     busy drops after done[2]; overrun_count stays 0.
//  T3 hold done[1]=0 for 25 cycles -> 2 ticks counted, overrun_count=2, no new
//     start[0]; after done[1], start[2]; clear_overrun -> 0.
//  T4 run 30 ticks -> frame_num 29->0 and seconds 0->1 on the same tick;
//     force overrun_count to 255 plus 1 more overrun -> stays 255.
//  T5 enable=0 for 7 cycles mid-period -> next tick delayed exactly 7 cycles;
//     stray done[2] asserted while in WAIT idx=0 -> ignored.
//  T6 resetn low during WAIT idx=1 -> busy, task_start, and counters 0 asynchronously;
//     first tick TICK_DIV+1 cycles after release.

Source files
------------

// File: rtl/frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// frame_scheduler_if
// Start/done handshake between the frame scheduler and its task engines.
//   task_start : one-hot, single-cycle start pulse from the scheduler
//   task_done  : per-engine done level or pulse, returned by the engines
// Modports:
//   master : the scheduler (drives task_start, observes task_done)
//   slave  : the engines   (observe task_start, drive task_done)
// -----------------------------------------------------------------------------
interface frame_scheduler_if #(
    parameter int NUM_TASKS = 3
);
    logic [NUM_TASKS-1:0] task_start;
    logic [NUM_TASKS-1:0] task_done;

    modport master (output task_start, input task_done);
    modport slave  (input task_start, output task_done);
endinterface

// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
// Derives the game frame tick from CLOCK_50 and runs the per-frame work as a
// fixed-order sequence of start/done handshakes with NUM_TASKS engines. Also
// keeps the frame-in-second and seconds counters for the HEX displays and
// counts ticks that arrived while the previous frame's work was still running.
// Ports:
//   CLOCK_50       in   system clock, rising edge
//   resetn         in   asynchronous active-low reset
//   enable         in   1 = tick divider runs, 0 = divider frozen (pause)
//   clear_overrun  in   synchronous clear of overrun_count
//   tasks          if   start/done handshake (master side)
//   frame_tick     out  1-cycle pulse per frame period
//   busy           out  1 while a frame's task sequence is in progress
//   frame_num      out  frame index within the second
//   seconds        out  elapsed seconds, wraps 255 -> 0
//   overrun_count  out  ticks dropped because the sequence was busy (saturating)
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int TICK_DIV       = 1666666,
    parameter int FRAMES_PER_SEC = 30,
    parameter int NUM_TASKS      = 3
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              enable,
    input  logic              clear_overrun,
    frame_scheduler_if.master tasks,
    output logic              frame_tick,
    output logic              busy,
    output logic [4:0]        frame_num,
    output logic [7:0]        seconds,
    output logic [7:0]        overrun_count
);

    localparam int DIV_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam int IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;

    localparam logic [DIV_W-1:0] TICK_MAX   = DIV_W'(TICK_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_TASKS - 1);
    localparam logic [4:0]       FRAME_LAST = 5'(FRAMES_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // One-hot select vector for engine number sel.
    function automatic logic [NUM_TASKS-1:0] onehot(input logic [IDX_W-1:0] sel);
        return {{(NUM_TASKS-1){1'b0}}, 1'b1} << sel;
    endfunction

    logic [DIV_W-1:0]     div_r;
    logic                 tick_r;
    logic [4:0]           frame_num_r;
    logic [7:0]           seconds_r;
    logic [7:0]           overrun_r;
    state_t               state_r;
    state_t               state_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_s;
    logic [NUM_TASKS-1:0] start_r;
    logic [NUM_TASKS-1:0] start_s;
    logic                 busy_r;
    logic                 busy_s;
    logic                 done_sel_s;

    // Tick divider: counts enabled cycles, pulses tick_r for one cycle on wrap.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            div_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else if (enable) begin
            if (div_r == TICK_MAX) begin
                div_r  <= {DIV_W{1'b0}};
                tick_r <= 1'b1;
            end else begin
                div_r  <= div_r + DIV_W'(1);
                tick_r <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

    // Frame and seconds counters advance on every tick, including dropped ones.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            frame_num_r <= 5'd0;
            seconds_r   <= 8'd0;
        end else if (tick_r) begin
            if (frame_num_r == FRAME_LAST) begin
                frame_num_r <= 5'd0;
                seconds_r   <= seconds_r + 8'd1;
            end else begin
                frame_num_r <= frame_num_r + 5'd1;
            end
        end
    end

    // Overrun counter: a clear wins over a same-cycle increment; saturates at 255.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            overrun_r <= 8'd0;
        end else if (clear_overrun) begin
            overrun_r <= 8'd0;
        end else if (tick_r && (state_r != ST_IDLE) && (overrun_r != 8'hFF)) begin
            overrun_r <= overrun_r + 8'd1;
        end
    end

    // Only the done bit of the engine currently being waited on matters.
    assign done_sel_s = |(tasks.task_done & onehot(idx_r));

    // Sequencer next state; start and busy are computed from the next state so
    // they can be registered alongside it.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_r) begin
                    state_s = ST_START;
                    idx_s   = {IDX_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_sel_s) begin
                    if (idx_r == IDX_LAST) begin
                        state_s = ST_IDLE;
                        idx_s   = {IDX_W{1'b0}};
                    end else begin
                        state_s = ST_START;
                        idx_s   = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {IDX_W{1'b0}};
            end
        endcase

        if (state_s == ST_START) begin
            start_s = onehot(idx_s);
        end else begin
            start_s = {NUM_TASKS{1'b0}};
        end
        busy_s = (state_s != ST_IDLE);
    end

    // Sequencer state plus its registered outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            start_r <= {NUM_TASKS{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            start_r <= start_s;
            busy_r  <= busy_s;
        end
    end

    assign tasks.task_start = start_r;
    assign frame_tick       = tick_r;
    assign busy             = busy_r;
    assign frame_num        = frame_num_r;
    assign seconds          = seconds_r;
    assign overrun_count    = overrun_r;

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
// Directed bench for frame_scheduler with TICK_DIV=9 (tick every 10 cycles),
// FRAMES_PER_SEC=30, NUM_TASKS=3. "Cycle k" is the state just after the k-th
// rising edge following reset release; outputs are sampled 1 time unit after
// the edge and inputs are changed at that same point.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

    logic       CLOCK_50;
    logic       resetn;
    logic       enable;
    logic       clear_overrun;
    logic       frame_tick;
    logic       busy;
    logic [4:0] frame_num;
    logic [7:0] seconds;
    logic [7:0] overrun_count;

    int n_checks;
    int n_fail;

    frame_scheduler_if #(.NUM_TASKS(3)) tif ();

    frame_scheduler #(
        .TICK_DIV       (9),
        .FRAMES_PER_SEC (30),
        .NUM_TASKS      (3)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .enable        (enable),
        .clear_overrun (clear_overrun),
        .tasks         (tif),
        .frame_tick    (frame_tick),
        .busy          (busy),
        .frame_num     (frame_num),
        .seconds       (seconds),
        .overrun_count (overrun_count)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Hold reset, then release it just after an edge; the next edge is cycle 1.
    task automatic do_reset(input logic en, input logic [2:0] done);
        resetn = 1'b0; enable = 1'b0; clear_overrun = 1'b0; tif.task_done = 3'b000;
        step(3);
        tif.task_done = done;
        resetn = 1'b1;
        enable = en;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b1; clear_overrun = 1'b0; tif.task_done = 3'b111;
        step(3);
        n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (tif.task_start !== 3'b000) begin n_fail++; $display("FAIL rst_start: got %b want 000", tif.task_start); end
        n_checks++; if (frame_num !== 5'd0) begin n_fail++; $display("FAIL rst_frame: got %0d want 0", frame_num); end
        n_checks++; if (seconds !== 8'd0) begin n_fail++; $display("FAIL rst_sec: got %0d want 0", seconds); end
        n_checks++; if (overrun_count !== 8'd0) begin n_fail++; $display("FAIL rst_ovr: got %0d want 0", overrun_count); end
    endtask

    // T1: ticks at cycles 10,20,30 and quiet outputs before the first tick.
    task automatic test_tick_period();
        logic exp_tick;
        do_reset(1'b1, 3'b111);
        for (int k = 1; k <= 30; k++) begin
            step(1);
            exp_tick = ((k % 10) == 0);
            n_checks++; if (frame_tick !== exp_tick) begin n_fail++; $display("FAIL t1_tick c%0d: got %b want %b", k, frame_tick, exp_tick); end
            if (k < 10) begin
                n_checks++;
                if ({busy, tif.task_start, frame_num, seconds, overrun_count} !== 25'd0) begin
                    n_fail++; $display("FAIL t1_quiet c%0d: busy %b start %b frame %0d sec %0d ovr %0d want all 0",
                                       k, busy, tif.task_start, frame_num, seconds, overrun_count);
                end
            end
            if (k == 11) begin
                n_checks++; if (tif.task_start !== 3'b001) begin n_fail++; $display("FAIL t1_start0: got %b want 001", tif.task_start); end
            end
            if (k == 17) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_idle: busy %b want 0", busy); end
            end
        end
        n_checks++; if (frame_num !== 5'd2) begin n_fail++; $display("FAIL t1_frame: got %0d want 2", frame_num); end
    endtask

    // T2: each done returned 2 cycles after its start -> starts at tick+1,+4,+7.
    task automatic test_sequence();
        logic [2:0] exp_start;
        do_reset(1'b1, 3'b000);
        step(10);
        for (int t = 0; t < 3; t++) begin
            step(1);
            tif.task_done = 3'b000;
            exp_start = 3'b001 << t;
            n_checks++; if (tif.task_start !== exp_start) begin n_fail++; $display("FAIL t2_start%0d: got %b want %b", t, tif.task_start, exp_start); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t2_busy%0d: got %b want 1", t, busy); end
            step(1);
            n_checks++; if (tif.task_start !== 3'b000) begin n_fail++; $display("FAIL t2_pulse%0d: got %b want 000", t, tif.task_start); end
            step(1);
            tif.task_done = exp_start;
        end
        step(1);
        tif.task_done = 3'b000;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t2_busy_end: got %b want 0", busy); end
        n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL t2_tick20: got %b want 1", frame_tick); end
        step(1);
        n_checks++; if (tif.task_start !== 3'b001) begin n_fail++; $display("FAIL t2_restart: got %b want 001", tif.task_start); end
        n_checks++; if (overrun_count !== 8'd0) begin n_fail++; $display("FAIL t2_ovr: got %0d want 0", overrun_count); end
    endtask

    // T3: engine 1 stalls across two ticks; both ticks are dropped and counted.
    task automatic test_overrun();
        logic [7:0] exp_ovr;
        do_reset(1'b1, 3'b000);
        step(11);
        n_checks++; if (tif.task_start !== 3'b001) begin n_fail++; $display("FAIL t3_start0: got %b want 001", tif.task_start); end
        step(1);
        tif.task_done = 3'b001;
        step(1);
        tif.task_done = 3'b000;
        n_checks++; if (tif.task_start !== 3'b010) begin n_fail++; $display("FAIL t3_start1: got %b want 010", tif.task_start); end
        for (int c = 14; c <= 36; c++) begin
            step(1);
            exp_ovr = (c >= 31) ? 8'd2 : ((c >= 21) ? 8'd1 : 8'd0);
            n_checks++; if (tif.task_start !== 3'b000) begin n_fail++; $display("FAIL t3_nostart c%0d: got %b want 000", c, tif.task_start); end
            n_checks++; if (overrun_count !== exp_ovr) begin n_fail++; $display("FAIL t3_ovr c%0d: got %0d want %0d", c, overrun_count, exp_ovr); end
        end
        step(1);
        tif.task_done = 3'b010;
        step(1);
        tif.task_done = 3'b000;
        n_checks++; if (tif.task_start !== 3'b100) begin n_fail++; $display("FAIL t3_start2: got %b want 100", tif.task_start); end
        step(1);
        tif.task_done = 3'b100;
        step(1);
        tif.task_done = 3'b000;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy_end: got %b want 0", busy); end
        step(1);
        n_checks++; if (overrun_count !== 8'd2) begin n_fail++; $display("FAIL t3_ovr_final: got %0d want 2", overrun_count); end
        n_checks++; if (frame_num !== 5'd4) begin n_fail++; $display("FAIL t3_frame: got %0d want 4", frame_num); end
        clear_overrun = 1'b1;
        step(1);
        clear_overrun = 1'b0;
        n_checks++; if (overrun_count !== 8'd0) begin n_fail++; $display("FAIL t3_clear: got %0d want 0", overrun_count); end
        step(8);
        n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL t3_tick50: got %b want 1", frame_tick); end
        clear_overrun = 1'b1;
        step(1);
        clear_overrun = 1'b0;
        n_checks++; if (overrun_count !== 8'd0) begin n_fail++; $display("FAIL t3_clear_prio: got %0d want 0", overrun_count); end
        step(10);
        n_checks++; if (overrun_count !== 8'd1) begin n_fail++; $display("FAIL t3_after_clear: got %0d want 1", overrun_count); end
    endtask

    // T4: frame/seconds wrap after 30 ticks, then overrun saturation at 255.
    task automatic test_wrap_saturate();
        logic [7:0] exp_ovr;
        do_reset(1'b1, 3'b111);
        step(300);
        n_checks++; if (frame_num !== 5'd29) begin n_fail++; $display("FAIL t4_frame29: got %0d want 29", frame_num); end
        n_checks++; if (seconds !== 8'd0) begin n_fail++; $display("FAIL t4_sec0: got %0d want 0", seconds); end
        step(1);
        n_checks++; if (frame_num !== 5'd0) begin n_fail++; $display("FAIL t4_frame_wrap: got %0d want 0", frame_num); end
        n_checks++; if (seconds !== 8'd1) begin n_fail++; $display("FAIL t4_sec1: got %0d want 1", seconds); end

        do_reset(1'b1, 3'b000);
        step(11);
        for (int k = 2; k <= 257; k++) begin
            step(10);
            exp_ovr = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
            n_checks++; if (overrun_count !== exp_ovr) begin n_fail++; $display("FAIL t4_ovr tick%0d: got %0d want %0d", k, overrun_count, exp_ovr); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t4_busy tick%0d: got %b want 1", k, busy); end
        end
        n_checks++; if (frame_num !== 5'd17) begin n_fail++; $display("FAIL t4_frame257: got %0d want 17", frame_num); end
        n_checks++; if (seconds !== 8'd8) begin n_fail++; $display("FAIL t4_sec257: got %0d want 8", seconds); end
    endtask

    // T5: 7-cycle pause delays the next tick by 7; stray done[2] is ignored.
    task automatic test_pause();
        do_reset(1'b1, 3'b111);
        step(14);
        enable = 1'b0;
        for (int c = 15; c <= 21; c++) begin
            step(1);
            n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL t5_paused_tick c%0d: got %b want 0", c, frame_tick); end
            if (c == 16) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t5_busy16: got %b want 1", busy); end
            end
            if (c == 17) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_busy17: got %b want 0", busy); end
            end
        end
        enable = 1'b1;
        for (int c = 22; c <= 26; c++) begin
            step(1);
            n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL t5_early_tick c%0d: got %b want 0", c, frame_tick); end
        end
        step(1);
        n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL t5_tick27: got %b want 1", frame_tick); end
        tif.task_done = 3'b000;
        step(1);
        n_checks++; if (tif.task_start !== 3'b001) begin n_fail++; $display("FAIL t5_start0: got %b want 001", tif.task_start); end
        tif.task_done = 3'b100;
        for (int c = 29; c <= 33; c++) begin
            step(1);
            n_checks++; if ({busy, tif.task_start} !== 4'b1000) begin n_fail++; $display("FAIL t5_stray c%0d: busy %b start %b want 1 000", c, busy, tif.task_start); end
        end
        tif.task_done = 3'b001;
        step(1);
        tif.task_done = 3'b000;
        n_checks++; if (tif.task_start !== 3'b010) begin n_fail++; $display("FAIL t5_start1: got %b want 010", tif.task_start); end
    endtask

    // T6: reset asserted while waiting on engine 1 clears everything at once.
    task automatic test_reset_mid();
        do_reset(1'b1, 3'b000);
        step(11);
        step(1);
        tif.task_done = 3'b001;
        step(1);
        tif.task_done = 3'b000;
        step(2);
        n_checks++; if ({busy, frame_num} !== 6'b1_00001) begin n_fail++; $display("FAIL t6_pre: busy %b frame %0d want 1 1", busy, frame_num); end
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({busy, tif.task_start, frame_tick, frame_num, seconds, overrun_count} !== 26'd0) begin
            n_fail++; $display("FAIL t6_async: busy %b start %b tick %b frame %0d sec %0d ovr %0d want all 0",
                               busy, tif.task_start, frame_tick, frame_num, seconds, overrun_count);
        end
        tif.task_done = 3'b010;
        step(2);
        n_checks++; if ({busy, tif.task_start} !== 4'b0000) begin n_fail++; $display("FAIL t6_held: busy %b start %b want 0 000", busy, tif.task_start); end
        tif.task_done = 3'b000;
        resetn = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step(1);
            n_checks++; if (frame_tick !== (c == 10)) begin n_fail++; $display("FAIL t6_tick c%0d: got %b want %b", c, frame_tick, (c == 10)); end
            n_checks++; if (tif.task_start !== 3'b000) begin n_fail++; $display("FAIL t6_nostart c%0d: got %b want 000", c, tif.task_start); end
        end
        step(1);
        n_checks++; if (tif.task_start !== 3'b001) begin n_fail++; $display("FAIL t6_start0: got %b want 001", tif.task_start); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn = 1'b0; enable = 1'b0; clear_overrun = 1'b0; tif.task_done = 3'b000;
        test_reset();
        test_tick_period();
        test_sequence();
        test_overrun();
        test_wrap_saturate();
        test_pause();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
